// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB master between NUM_REQ requesters.
// Define APB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ERR_WIDTH  = 2
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            rw_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [ERR_WIDTH-1:0]          fail_o,
    output logic                          busy_o,
    output logic                          TRANSFER_arb_o,
    output logic                          RW_arb_o,
    output logic [ADDR_WIDTH-1:0]         ADDR_arb_o,
    output logic [DATA_WIDTH-1:0]         WDATA_arb_o,
    input  logic                          DONE_arb_i,
    input  logic [DATA_WIDTH-1:0]         RDATA_arb_i,
    input  logic [ERR_WIDTH-1:0]          FAIL_arb_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [NUM_REQ-1:0]      gnt_r, gnt_s;
    logic [NUM_REQ-1:0]      done_r, done_s;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_s;
    logic [ERR_WIDTH-1:0]    fail_r, fail_s;
    logic                    busy_r, busy_s;
    logic                    transfer_r, transfer_s;
    logic                    rw_r, rw_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
    logic                    win_found_s;
    logic [IDX_W-1:0]        win_idx_s;
    int                      cand_s;
`ifndef APB_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]        ptr_r, ptr_s;
`endif

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Winner search: first set request at or above the pointer, wrapping around.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        cand_s      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
            cand_s = i;
`else
            cand_s = int'(ptr_r) + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
`endif
            if (!win_found_s && req_i[IDX_W'(cand_s)]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(cand_s);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        gnt_s   = gnt_r;
        done_s  = {NUM_REQ{1'b0}};
        rdata_s = rdata_r;
        fail_s  = fail_r;
        rw_s    = rw_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
`ifndef APB_ARB_FIXED_PRIO_EN
        ptr_s   = ptr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s = ST_ISSUE;
                    idx_s   = win_idx_s;
                    gnt_s   = idx_to_onehot(win_idx_s);
                    rw_s    = rw_i[win_idx_s];
                    addr_s  = addr_i[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_s = wdata_i[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (DONE_arb_i) begin
                    state_s = ST_RESP;
                    rdata_s = RDATA_arb_i;
                    fail_s  = FAIL_arb_i;
                    gnt_s   = {NUM_REQ{1'b0}};
                    done_s  = idx_to_onehot(idx_r);
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
`ifndef APB_ARB_FIXED_PRIO_EN
                ptr_s   = (idx_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
`endif
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {NUM_REQ{1'b0}};
            end
        endcase
        busy_s     = (state_s != ST_IDLE);
        transfer_s = (state_s == ST_ISSUE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            gnt_r      <= {NUM_REQ{1'b0}};
            done_r     <= {NUM_REQ{1'b0}};
            rdata_r    <= {DATA_WIDTH{1'b0}};
            fail_r     <= {ERR_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            transfer_r <= 1'b0;
            rw_r       <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
`ifndef APB_ARB_FIXED_PRIO_EN
            ptr_r      <= {IDX_W{1'b0}};
`endif
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            gnt_r      <= gnt_s;
            done_r     <= done_s;
            rdata_r    <= rdata_s;
            fail_r     <= fail_s;
            busy_r     <= busy_s;
            transfer_r <= transfer_s;
            rw_r       <= rw_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
`ifndef APB_ARB_FIXED_PRIO_EN
            ptr_r      <= ptr_s;
`endif
        end
    end

    assign gnt_o          = gnt_r;
    assign done_o         = done_r;
    assign rdata_o        = rdata_r;
    assign fail_o         = fail_r;
    assign busy_o         = busy_r;
    assign TRANSFER_arb_o = transfer_r;
    assign RW_arb_o       = rw_r;
    assign ADDR_arb_o     = addr_r;
    assign WDATA_arb_o    = wdata_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: the bench plays the APB master and the requesters,
// and predicts grants with a transaction-level round-robin model.
module tb_apb_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int EW = 2;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b1;
    logic [N-1:0]    req_i, rw_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o, done_o;
    logic [DW-1:0]   rdata_o;
    logic [EW-1:0]   fail_o;
    logic            busy_o, TRANSFER_arb_o, RW_arb_o;
    logic [AW-1:0]   ADDR_arb_o;
    logic [DW-1:0]   WDATA_arb_o;
    logic            DONE_arb_i;
    logic [DW-1:0]   RDATA_arb_i;
    logic [EW-1:0]   FAIL_arb_i;

    apb_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(EW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .fail_o(fail_o),
        .busy_o(busy_o), .TRANSFER_arb_o(TRANSFER_arb_o), .RW_arb_o(RW_arb_o),
        .ADDR_arb_o(ADDR_arb_o), .WDATA_arb_o(WDATA_arb_o), .DONE_arb_i(DONE_arb_i),
        .RDATA_arb_i(RDATA_arb_i), .FAIL_arb_i(FAIL_arb_i)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int            gidx;
        logic [AW-1:0] addr;
        logic          rw;
        logic [DW-1:0] wdata;
        int            pulses;
        bit            stable;
        logic [N-1:0]  done;
        logic [DW-1:0] rdata;
        logic [EW-1:0] fail;
        logic [N-1:0]  gnt;
        logic          idle_busy;
        logic [N-1:0]  idle_done;
    } obs_t;

    logic [N-1:0]  tb_req, tb_rw;
    logic [AW-1:0] tb_addr [N];
    logic [DW-1:0] tb_wdata [N];
    int vectors = 0;
    int miscompares = 0;
    int model_ptr = 0;

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW]  = tb_addr[k];
            wdata_i[k*DW +: DW] = tb_wdata[k];
        end
        req_i = tb_req;
        rw_i  = tb_rw;
    endtask

    function automatic int exp_winner(input logic [N-1:0] req);
`ifdef APB_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (req[k]) return k;
`else
        for (int off = 0; off < N; off++) if (req[(model_ptr + off) % N]) return (model_ptr + off) % N;
`endif
        return -1;
    endfunction

    function automatic int decode(input logic [N-1:0] g);
        if ($countones(g) != 1) return -1;
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    // Acts as the APB master for one transaction and records what it observed.
    task automatic master_txn(input int lat, input logic [DW-1:0] rd, input logic [EW-1:0] fl,
                              input logic [N-1:0] drop, input bit poke, output obs_t o);
        int wc = 0;
        o = '{gidx: -1, addr: '0, rw: 1'b0, wdata: '0, pulses: 0, stable: 1'b1, done: '0,
              rdata: '0, fail: '0, gnt: '1, idle_busy: 1'b1, idle_done: '1};
        @(negedge PCLK);
        while (gnt_o == '0 && wc < 20) begin
            @(negedge PCLK);
            wc++;
        end
        if (gnt_o == '0) return;
        o.gidx = decode(gnt_o);
        o.addr = ADDR_arb_o;
        o.rw = RW_arb_o;
        o.wdata = WDATA_arb_o;
        o.pulses += int'(TRANSFER_arb_o);
        tb_req = tb_req & ~drop;
        if (poke && o.gidx >= 0) tb_addr[o.gidx] = ~tb_addr[o.gidx];
        apply();
        for (int c = 1; c <= lat; c++) begin
            @(negedge PCLK);
            o.pulses += int'(TRANSFER_arb_o);
            if (ADDR_arb_o !== o.addr || RW_arb_o !== o.rw || WDATA_arb_o !== o.wdata) o.stable = 1'b0;
            if (c == lat) begin
                DONE_arb_i = 1'b1;
                RDATA_arb_i = rd;
                FAIL_arb_i = fl;
            end
        end
        @(negedge PCLK);
        DONE_arb_i = 1'b0;
        RDATA_arb_i = $urandom;
        FAIL_arb_i = EW'($urandom);
        o.pulses += int'(TRANSFER_arb_o);
        if (ADDR_arb_o !== o.addr || RW_arb_o !== o.rw || WDATA_arb_o !== o.wdata) o.stable = 1'b0;
        o.done = done_o;
        o.rdata = rdata_o;
        o.fail = fail_o;
        o.gnt = gnt_o;
        @(negedge PCLK);
        o.pulses += int'(TRANSFER_arb_o);
        o.idle_busy = busy_o;
        o.idle_done = done_o;
    endtask

    task automatic test_reset();
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        vectors++;
        if ({gnt_o, done_o, rdata_o, fail_o, busy_o, TRANSFER_arb_o, RW_arb_o, ADDR_arb_o, WDATA_arb_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: gnt=%b done=%b busy=%b tr=%b addr=%h required all zero", gnt_o, done_o, busy_o, TRANSFER_arb_o, ADDR_arb_o);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        model_ptr = 0;
        @(negedge PCLK);
        vectors++;
        if (busy_o !== 1'b0 || gnt_o !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b gnt=%b required 0/0000", busy_o, gnt_o);
        end
    endtask

    task automatic test_single_read();
        obs_t o;
        int exp;
        tb_req = 4'b0010; tb_addr[1] = 32'h0000_0010; tb_rw[1] = 1'b0; tb_wdata[1] = $urandom;
        apply();
        exp = exp_winner(tb_req);
        master_txn(3, 32'hDEAD_BEEF, 2'b00, 4'b0010, 1'b0, o);
        model_ptr = (exp + 1) % N;
        vectors++;
        if (o.gidx !== exp || o.addr !== 32'h10 || o.rw !== 1'b0) begin
            miscompares++;
            $display("FAIL single_cmd: gidx=%0d addr=%h rw=%b required %0d/00000010/0", o.gidx, o.addr, o.rw, exp);
        end
        vectors++;
        if (o.pulses !== 1 || o.stable !== 1'b1) begin
            miscompares++;
            $display("FAIL single_strobe: pulses=%0d stable=%0d required 1/1", o.pulses, o.stable);
        end
        vectors++;
        if (o.done !== 4'b0010 || o.rdata !== 32'hDEAD_BEEF || o.fail !== 2'b00 || o.gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_resp: done=%b rdata=%h fail=%b gnt=%b required 0010/deadbeef/00/0000", o.done, o.rdata, o.fail, o.gnt);
        end
        vectors++;
        if (o.idle_busy !== 1'b0 || o.idle_done !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_after: busy=%b done=%b required 0/0000", o.idle_busy, o.idle_done);
        end
    endtask

    task automatic test_round_robin();
        obs_t o;
        int exp;
        @(negedge PCLK);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        model_ptr = 0;
        for (int k = 0; k < N; k++) tb_addr[k] = 32'h100 * k + $urandom_range(0, 255);
        tb_req = 4'b1111;
        apply();
        for (int t = 0; t < 8; t++) begin
            exp = exp_winner(tb_req);
            master_txn($urandom_range(1, 4), $urandom, 2'b00, 4'b0000, 1'b0, o);
            model_ptr = (exp + 1) % N;
            vectors++;
            if (o.gidx !== exp || o.addr !== tb_addr[exp] || o.done !== (4'b0001 << exp)) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: gidx=%0d addr=%h done=%b required %0d/%h", t, o.gidx, o.addr, o.done, exp, tb_addr[exp]);
            end
        end
        tb_req = 4'b0000;
        apply();
    endtask

    task automatic test_error_write();
        obs_t o;
        tb_req = 4'b0100; tb_rw[2] = 1'b1; tb_wdata[2] = 32'h1234_5678; tb_addr[2] = $urandom;
        apply();
        master_txn(2, 32'hCAFE_0000, 2'b10, 4'b0100, 1'b0, o);
        model_ptr = 3;
        vectors++;
        if (o.gidx !== 2 || o.wdata !== 32'h1234_5678 || o.rw !== 1'b1) begin
            miscompares++;
            $display("FAIL err_cmd: gidx=%0d wdata=%h rw=%b required 2/12345678/1", o.gidx, o.wdata, o.rw);
        end
        vectors++;
        if (o.fail !== 2'b10 || o.done !== 4'b0100 || o.rdata !== 32'hCAFE_0000) begin
            miscompares++;
            $display("FAIL err_resp: fail=%b done=%b rdata=%h required 10/0100/cafe0000", o.fail, o.done, o.rdata);
        end
        tb_rw[2] = 1'b0;
        apply();
    endtask

    task automatic test_withdraw();
        obs_t o;
        tb_req = 4'b1000; tb_addr[3] = $urandom;
        apply();
        master_txn(4, $urandom, 2'b01, 4'b1000, 1'b0, o);
        model_ptr = 0;
        vectors++;
        if (o.gidx !== 3 || o.done !== 4'b1000 || o.fail !== 2'b01) begin
            miscompares++;
            $display("FAIL withdraw_done: gidx=%0d done=%b fail=%b required 3/1000/01", o.gidx, o.done, o.fail);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            vectors++;
            if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL withdraw_regrant[%0d]: gnt=%b busy=%b required 0000/0", c, gnt_o, busy_o);
            end
        end
    endtask

    task automatic test_spurious();
        obs_t o;
        logic [AW-1:0] a0;
        logic [DW-1:0] rd;
        tb_req = 4'b0000;
        apply();
        @(negedge PCLK);
        DONE_arb_i = 1'b1;
        @(negedge PCLK);
        DONE_arb_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (done_o !== 4'b0000 || busy_o !== 1'b0 || gnt_o !== 4'b0000) begin
                miscompares++;
                $display("FAIL spurious_done[%0d]: done=%b busy=%b gnt=%b required 0000/0/0000", c, done_o, busy_o, gnt_o);
            end
            @(negedge PCLK);
        end
        tb_req = 4'b0010; tb_addr[1] = $urandom; a0 = tb_addr[1];
        rd = $urandom;
        apply();
        master_txn(4, rd, 2'b00, 4'b0010, 1'b1, o);
        model_ptr = 2;
        vectors++;
        if (o.gidx !== 1 || o.addr !== a0 || o.stable !== 1'b1 || ADDR_arb_o !== a0) begin
            miscompares++;
            $display("FAIL late_addr: gidx=%0d addr=%h stable=%0d now=%h required 1/%h/1", o.gidx, o.addr, o.stable, ADDR_arb_o, a0);
        end
        repeat (3) @(negedge PCLK);
        vectors++;
        if (rdata_o !== rd || ADDR_arb_o !== a0) begin
            miscompares++;
            $display("FAIL hold_idle: rdata=%h addr=%h required %h/%h", rdata_o, ADDR_arb_o, rd, a0);
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        int wc = 0;
        bit saw_done = 1'b0;
        int exp;
        tb_req = 4'b0100;
        apply();
        exp = exp_winner(tb_req);
        @(negedge PCLK);
        while (gnt_o == '0 && wc < 20) begin
            @(negedge PCLK);
            wc++;
        end
        vectors++;
        if (decode(gnt_o) !== exp) begin
            miscompares++;
            $display("FAIL midwait_grant: gidx=%0d required %0d", decode(gnt_o), exp);
        end
        repeat (2) @(negedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        vectors++;
        if ({gnt_o, done_o, rdata_o, fail_o, busy_o, TRANSFER_arb_o, RW_arb_o, ADDR_arb_o, WDATA_arb_o} !== '0) begin
            miscompares++;
            $display("FAIL midwait_async: gnt=%b busy=%b addr=%h required all zero", gnt_o, busy_o, ADDR_arb_o);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge PCLK);
            if (done_o !== '0) saw_done = 1'b1;
        end
        tb_req = 4'b1111;
        apply();
        PRESETn = 1'b1;
        model_ptr = 0;
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midwait_nodone: saw_done=%0d required 0", saw_done);
        end
        master_txn(1, $urandom, 2'b00, 4'b1111, 1'b0, o);
        model_ptr = 1;
        vectors++;
        if (o.gidx !== 0 || o.done !== 4'b0001) begin
            miscompares++;
            $display("FAIL midwait_ptr: gidx=%0d done=%b required 0/0001", o.gidx, o.done);
        end
    endtask

    task automatic test_random();
        obs_t o;
        int exp, lat;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, rd;
        logic erw;
        logic [EW-1:0] fl;
        for (int t = 0; t < 40; t++) begin
            tb_req = N'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                tb_addr[k] = $urandom;
                tb_wdata[k] = $urandom;
                tb_rw[k] = 1'($urandom);
            end
            apply();
            exp = exp_winner(tb_req);
            ea = tb_addr[exp]; ew = tb_wdata[exp]; erw = tb_rw[exp];
            lat = $urandom_range(1, 5);
            rd = $urandom;
            fl = EW'($urandom);
            master_txn(lat, rd, fl, 4'b1111, 1'($urandom), o);
            model_ptr = (exp + 1) % N;
            vectors++;
            if (o.gidx !== exp || o.addr !== ea || o.wdata !== ew || o.rw !== erw) begin
                miscompares++;
                $display("FAIL rand_cmd[%0d]: gidx=%0d addr=%h wd=%h rw=%b required %0d/%h/%h/%b", t, o.gidx, o.addr, o.wdata, o.rw, exp, ea, ew, erw);
            end
            vectors++;
            if (o.done !== (4'b0001 << exp) || o.rdata !== rd || o.fail !== fl || o.pulses !== 1 || o.stable !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_resp[%0d]: done=%b rdata=%h fail=%b pulses=%0d stable=%0d required rdata %h fail %b", t, o.done, o.rdata, o.fail, o.pulses, o.stable, rd, fl);
            end
        end
    endtask

    initial begin
        DONE_arb_i = 1'b0;
        RDATA_arb_i = '0;
        FAIL_arb_i = '0;
        tb_req = '0;
        tb_rw = '0;
        for (int k = 0; k < N; k++) begin
            tb_addr[k] = '0;
            tb_wdata[k] = '0;
        end
        apply();
        test_reset();
        test_single_read();
        test_round_robin();
        test_error_write();
        test_withdraw();
        test_spurious();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
